// File: rtl/ihpsg13_bist_pkg.sv
// ---------------------------------------------------------------------------
// ihpsg13_bist_pkg
//
// Shared definitions for the March C- BIST engine of the 512x16 1-port SRAM:
//   - bist_state_e : controller states (IDLE / RUN / FLUSH / DONE)
//   - march_op_e   : a single march operation (read/write of data0/data1)
//   - elem_desc_t  : one march element (direction, first op, second op)
//   - elem_desc()  : the six-entry March C- element table
//   - small helpers that classify an op (read, write, data polarity)
// ---------------------------------------------------------------------------
package ihpsg13_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int NUM_ELEM = 6;

    typedef logic [2:0] elem_idx_t;

    // Element index one past the last element: all ops have been issued.
    localparam elem_idx_t ELEM_END = elem_idx_t'(NUM_ELEM);

    // R0/W0 use data0 (the background), R1/W1 use data1 = ~data0.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_R0   = 3'd1,
        OP_R1   = 3'd2,
        OP_W0   = 3'd3,
        OP_W1   = 3'd4
    } march_op_e;

    typedef struct packed {
        logic      down;   // 1: address N-1..0, 0: address 0..N-1
        march_op_e op0;    // first op at each address
        march_op_e op1;    // second op at each address (OP_NONE if single-op)
    } elem_desc_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_desc_t elem_desc(input elem_idx_t idx);
        elem_desc_t d;
        d.down = 1'b0;
        d.op0  = OP_NONE;
        d.op1  = OP_NONE;
        case (idx)
            3'd0: begin d.down = 1'b0; d.op0 = OP_W0; d.op1 = OP_NONE; end
            3'd1: begin d.down = 1'b0; d.op0 = OP_R0; d.op1 = OP_W1;   end
            3'd2: begin d.down = 1'b0; d.op0 = OP_R1; d.op1 = OP_W0;   end
            3'd3: begin d.down = 1'b1; d.op0 = OP_R0; d.op1 = OP_W1;   end
            3'd4: begin d.down = 1'b1; d.op0 = OP_R1; d.op1 = OP_W0;   end
            3'd5: begin d.down = 1'b0; d.op0 = OP_R0; d.op1 = OP_NONE; end
            default: begin d.down = 1'b0; d.op0 = OP_NONE; d.op1 = OP_NONE; end
        endcase
        return d;
    endfunction

    function automatic logic elem_down(input elem_idx_t idx);
        elem_desc_t d;
        d = elem_desc(idx);
        return d.down;
    endfunction

    function automatic logic op_is_read(input march_op_e op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    function automatic logic op_is_write(input march_op_e op);
        return (op == OP_W0) || (op == OP_W1);
    endfunction

    // 1 when the op uses data1 (inverted background).
    function automatic logic op_pol(input march_op_e op);
        return (op == OP_R1) || (op == OP_W1);
    endfunction

endpackage

// File: rtl/ihpsg13_bist_cmp.sv
// ---------------------------------------------------------------------------
// ihpsg13_bist_cmp
//
// Read-data checker for the March C- BIST engine. The SRAM returns read data
// the cycle after the read edge, so the expected data and address of each
// read are held in a one-stage pipeline and compared against A_DOUT on the
// following edge. The first miscompare of a run is captured; later ones only
// keep FAIL asserted.
//
// Ports:
//   clk, rst    : BIST clock, asynchronous active-high reset
//   clear       : start of a run; clears pipeline and all fail status
//   rd_valid    : a read is being presented to the SRAM this cycle
//   rd_addr     : address of that read
//   rd_exp      : data that read is expected to return
//   dout        : SRAM read data (valid the cycle after the read edge)
//   fail        : sticky, at least one miscompare since clear
//   fail_addr   : address of the first miscompare
//   fail_bits   : dout XOR expected at the first miscompare
// ---------------------------------------------------------------------------
module ihpsg13_bist_cmp #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] dout,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_bits
);

    logic              pipe_valid_q, pipe_valid_d;
    logic [ADDR_W-1:0] pipe_addr_q,  pipe_addr_d;
    logic [DATA_W-1:0] pipe_exp_q,   pipe_exp_d;
    logic              fail_q,       fail_d;
    logic [ADDR_W-1:0] fail_addr_q,  fail_addr_d;
    logic [DATA_W-1:0] fail_bits_q,  fail_bits_d;

    logic [DATA_W-1:0] diff;
    logic              miscmp;

    always_comb begin
        diff         = dout ^ pipe_exp_q;
        miscmp       = pipe_valid_q && (diff != '0);

        pipe_valid_d = rd_valid;
        pipe_addr_d  = rd_addr;
        pipe_exp_d   = rd_exp;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_bits_d  = fail_bits_q;

        if (clear) begin
            pipe_valid_d = 1'b0;
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_bits_d  = '0;
        end else if (miscmp) begin
            fail_d = 1'b1;
            // Only the first miscompare of the run is recorded.
            if (!fail_q) begin
                fail_addr_d = pipe_addr_q;
                fail_bits_d = diff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= 1'b0;
            pipe_addr_q  <= '0;
            pipe_exp_q   <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_bits_q  <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_exp_q   <= pipe_exp_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_bits_q  <= fail_bits_d;
        end
    end

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_bits = fail_bits_q;

endmodule

// File: rtl/ihpsg13_sram_bist_march_ctrl.sv
// ---------------------------------------------------------------------------
// ihpsg13_sram_bist_march_ctrl
//
// March C- memory-BIST engine driving the BIST port of one 1-port SRAM macro.
// A START pulse (sampled together with PAT) launches a run of 10*N single-
// cycle ops; every read is checked one cycle later by ihpsg13_bist_cmp. After
// the last read has been compared the engine sits in DONE with the pass/fail
// result until the next START.
//
// Timing, with START sampled at edge 0: op i is sampled by the SRAM at edge
// i+1, the last op at edge 10N, and DONE rises at edge 10N+1 (one FLUSH cycle
// for the final compare).
//
// Ports:
//   A_BIST_CLK, A_BIST_RST : clock, asynchronous active-high reset
//   START, PAT             : run start pulse and data background select
//   A_DOUT                 : SRAM read data
//   A_BIST_EN/MEN/WEN/REN  : BIST enable, memory enable, write, read strobes
//   A_BIST_ADDR/DIN/BM     : op address, write data, bit mask
//   BUSY, DONE             : run in progress / run finished (sticky)
//   FAIL, FAIL_ADDR, FAIL_BITS : result and first-miscompare capture
// ---------------------------------------------------------------------------
module ihpsg13_sram_bist_march_ctrl
    import ihpsg13_bist_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              A_BIST_CLK,
    input  logic              A_BIST_RST,
    input  logic              START,
    input  logic              PAT,
    input  logic [DATA_W-1:0] A_DOUT,
    output logic              A_BIST_EN,
    output logic              A_BIST_MEN,
    output logic              A_BIST_WEN,
    output logic              A_BIST_REN,
    output logic [ADDR_W-1:0] A_BIST_ADDR,
    output logic [DATA_W-1:0] A_BIST_DIN,
    output logic [DATA_W-1:0] A_BIST_BM,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [DATA_W-1:0] FAIL_BITS
);

    // Alternating background 0x5555... for any data width.
    function automatic logic [DATA_W-1:0] alt_pattern();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W; i++) begin
            v[i] = (i % 2) == 0;
        end
        return v;
    endfunction

    localparam logic [DATA_W-1:0] ALT_BG   = alt_pattern();
    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

    // Sequencer state: elem/addr/phase point at the next op to issue.
    bist_state_e       state_q, state_d;
    elem_idx_t         elem_q,  elem_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              phase_q, phase_d;
    logic              pat_q,   pat_d;

    // Registered SRAM-side outputs and status.
    logic              men_q,     men_d;
    logic              wen_q,     wen_d;
    logic              ren_q,     ren_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [DATA_W-1:0] din_q,     din_d;
    logic [DATA_W-1:0] exp_q,     exp_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // Op-generation scratch.
    logic              issue;
    elem_idx_t         cur_elem;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_phase;
    logic              cur_pat;
    elem_desc_t        desc;
    march_op_e         op;
    logic [DATA_W-1:0] bg;
    logic [DATA_W-1:0] op_data;
    logic              at_end;
    elem_idx_t         next_elem;
    logic              cmp_clear;

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        pat_d     = pat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cmp_clear = 1'b0;

        issue     = 1'b0;
        cur_elem  = elem_q;
        cur_addr  = addr_q;
        cur_phase = phase_q;
        cur_pat   = pat_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    cmp_clear = 1'b1;
                    pat_d     = PAT;
                    // The first op goes out on the START edge itself so the
                    // SRAM samples it one edge later.
                    issue     = 1'b1;
                    cur_elem  = '0;
                    cur_addr  = '0;
                    cur_phase = 1'b0;
                    cur_pat   = PAT;
                end
            end
            ST_RUN: begin
                if (elem_q == ELEM_END) begin
                    state_d = ST_FLUSH;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The last read's data is compared on this edge.
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        desc      = elem_desc(cur_elem);
        op        = cur_phase ? desc.op1 : desc.op0;
        bg        = cur_pat ? ALT_BG : '0;
        op_data   = op_pol(op) ? ~bg : bg;
        at_end    = desc.down ? (cur_addr == '0) : (cur_addr == MAX_ADDR);
        next_elem = cur_elem + 3'd1;

        men_d     = issue;
        wen_d     = issue && op_is_write(op);
        ren_d     = issue && op_is_read(op);
        op_addr_d = issue ? cur_addr : '0;
        din_d     = wen_d ? op_data : '0;
        exp_d     = ren_d ? op_data : '0;

        if (issue) begin
            if (!cur_phase && (desc.op1 != OP_NONE)) begin
                // Second op at the same address.
                elem_d  = cur_elem;
                addr_d  = cur_addr;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (at_end) begin
                    // Wrap to the start address of the next element.
                    elem_d = next_elem;
                    addr_d = elem_down(next_elem) ? MAX_ADDR : '0;
                end else begin
                    elem_d = cur_elem;
                    addr_d = desc.down ? (cur_addr - ADDR_W'(1))
                                       : (cur_addr + ADDR_W'(1));
                end
            end
        end
    end

    always_ff @(posedge A_BIST_CLK or posedge A_BIST_RST) begin
        if (A_BIST_RST) begin
            state_q   <= ST_IDLE;
            elem_q    <= '0;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            pat_q     <= 1'b0;
            men_q     <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            op_addr_q <= '0;
            din_q     <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            pat_q     <= pat_d;
            men_q     <= men_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            op_addr_q <= op_addr_d;
            din_q     <= din_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The read presented now is sampled at the next edge; its data is
    // compared one edge after that inside the checker.
    ihpsg13_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (A_BIST_CLK),
        .rst       (A_BIST_RST),
        .clear     (cmp_clear),
        .rd_valid  (ren_q),
        .rd_addr   (op_addr_q),
        .rd_exp    (exp_q),
        .dout      (A_DOUT),
        .fail      (FAIL),
        .fail_addr (FAIL_ADDR),
        .fail_bits (FAIL_BITS)
    );

    assign A_BIST_EN   = busy_q;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = op_addr_q;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = {DATA_W{busy_q}};
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_ihpsg13_sram_bist_march_ctrl.sv
// Testbench for ihpsg13_sram_bist_march_ctrl: behavioural SRAM with an
// optional stuck-at-1 cell, op scoreboard against a march-notation model,
// and result checks per run.
module tb_ihpsg13_sram_bist_march_ctrl;

  localparam int N    = 512;
  localparam int W    = 43;  // {edge[13:0], en, bm_ok, wen, ren, addr[8:0], data[15:0]}
  localparam int LIMIT = 10 * N + 20;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pat;
  logic [15:0] a_dout;
  logic        a_bist_en, a_bist_men, a_bist_wen, a_bist_ren;
  logic [8:0]  a_bist_addr;
  logic [15:0] a_bist_din, a_bist_bm;
  logic        busy, done, fail;
  logic [8:0]  fail_addr;
  logic [15:0] fail_bits;

  ihpsg13_sram_bist_march_ctrl #(.ADDR_W(9), .DATA_W(16)) dut (
    .A_BIST_CLK  (clk),
    .A_BIST_RST  (rst),
    .START       (start),
    .PAT         (pat),
    .A_DOUT      (a_dout),
    .A_BIST_EN   (a_bist_en),
    .A_BIST_MEN  (a_bist_men),
    .A_BIST_WEN  (a_bist_wen),
    .A_BIST_REN  (a_bist_ren),
    .A_BIST_ADDR (a_bist_addr),
    .A_BIST_DIN  (a_bist_din),
    .A_BIST_BM   (a_bist_bm),
    .BUSY        (busy),
    .DONE        (done),
    .FAIL        (fail),
    .FAIL_ADDR   (fail_addr),
    .FAIL_BITS   (fail_bits)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_no  = 0;
  int          start_edge = 0;
  int          wr_cnt, rd_cnt;
  int          fault_addr;
  logic [15:0] fault_mask;
  logic [15:0] mem [N];
  logic        rd_pend;
  logic [15:0] rd_val;
  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];

  // March C- in textbook notation: direction then (op, data) pairs.
  string march_elems[6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural SRAM + op monitor ----------------
  always @(posedge clk) begin
    edge_no++;
    #1;
    if (rd_pend) begin
      a_dout  = rd_val;
      rd_pend = 1'b0;
    end
  end

  // Outputs are stable at the falling edge; the op seen here is the one the
  // SRAM samples at the next rising edge.
  always @(negedge clk) begin
    if (a_bist_men) begin
      obs = {14'(edge_no + 1 - start_edge), a_bist_en, (a_bist_bm == 16'hFFFF),
             a_bist_wen, a_bist_ren, a_bist_addr, (a_bist_wen ? a_bist_din : 16'h0)};
      if (exp_q.size() == 0) check("op_unexpected", 64'(obs), 64'(0));
      else check("op", 64'(obs), 64'(exp_q.pop_front()));
      if (a_bist_wen) begin
        wr_cnt++;
        mem[a_bist_addr] = a_bist_din;
      end
      if (a_bist_ren) begin
        rd_cnt++;
        rd_val  = mem[a_bist_addr] | ((int'(a_bist_addr) == fault_addr) ? fault_mask : 16'h0);
        rd_pend = 1'b1;
      end
    end else if (a_bist_wen || a_bist_ren) begin
      check("stray_strobe", 64'({a_bist_wen, a_bist_ren}), 64'(0));
    end
  end

  // ---------------- reference model ----------------
  // Walks the march notation over an ideal memory with the same stuck-at
  // fault, filling the op queue and predicting the first miscompare.
  task automatic build_model(input logic p, input int fa, input logic [15:0] fm,
                             output logic f, output int fadr, output logic [15:0] fbits,
                             output int f_edge, output int n_wr, output int n_rd);
    logic [15:0] m [N];
    logic [15:0] bg, d, got;
    int          edge_n, a;
    string       s;
    bg = p ? 16'h5555 : 16'h0000;
    exp_q.delete();
    f = 1'b0; fadr = 0; fbits = 16'h0; f_edge = -1;
    edge_n = 0; n_wr = 0; n_rd = 0;
    for (int e = 0; e < 6; e++) begin
      s = march_elems[e];
      for (int i = 0; i < N; i++) begin
        a = (s[0] == "D") ? (N - 1 - i) : i;
        for (int j = 1; j + 1 < s.len(); j += 2) begin
          d = (s[j+1] == "1") ? ~bg : bg;
          edge_n++;
          if (s[j] == "w") begin
            m[a] = d;
            n_wr++;
            exp_q.push_back({14'(edge_n), 1'b1, 1'b1, 1'b1, 1'b0, 9'(a), d});
          end else begin
            n_rd++;
            exp_q.push_back({14'(edge_n), 1'b1, 1'b1, 1'b0, 1'b1, 9'(a), 16'h0});
            got = m[a] | ((a == fa) ? fm : 16'h0);
            if (got !== d && !f) begin
              f = 1'b1; fadr = a; fbits = got ^ d; f_edge = edge_n + 1;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_march(input logic p, input int fa, input logic [15:0] fm,
                           input int extra_start, input int abort_at);
    logic        f;
    int          fadr, f_edge, n_wr, n_rd, done_at;
    logic [15:0] fbits;
    bit          aborted;
    build_model(p, fa, fm, f, fadr, fbits, f_edge, n_wr, n_rd);
    fault_addr = fa; fault_mask = fm;
    wr_cnt = 0; rd_cnt = 0; done_at = -1; aborted = 0;

    @(negedge clk);
    start = 1'b1; pat = p;
    @(posedge clk);
    #1;
    start_edge = edge_no;
    start = 1'b0; pat = 1'($urandom);
    check("start_status", 64'({busy, done, fail, fail_addr, fail_bits}), 64'({1'b1, 1'b0, 1'b0, 9'h0, 16'h0}));

    for (int k = 1; k <= LIMIT; k++) begin
      start = (k == extra_start);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == f_edge - 1) check("fail_before_first", 64'(fail), 64'(0));
      if (k == f_edge) check("fail_first", 64'({fail, fail_addr, fail_bits}), 64'({1'b1, 9'(fadr), fbits}));
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_sram", 64'({a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm}), 64'(0));
        check("abort_status", 64'({busy, done, fail, fail_addr, fail_bits}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rd_pend = 1'b0;
        aborted = 1;
        break;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end

    if (!aborted) begin
      check("done_edge", 64'(done_at), 64'(10 * N + 1));
      check("result", 64'({fail, fail_addr, fail_bits}), 64'({f, 9'(fadr), fbits}));
      check("busy_off", 64'(busy), 64'(0));
      check("idle_strobes", 64'({a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_bm}), 64'(0));
      check("wr_count", 64'(wr_cnt), 64'(n_wr));
      check("rd_count", 64'(rd_cnt), 64'(n_rd));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("done_sticky", 64'({done, fail}), 64'({1'b1, f}));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; pat = 1'b0; a_dout = 16'h0;
    rd_pend = 1'b0; rd_val = 16'h0; fault_addr = -1; fault_mask = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sram", 64'({a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm}), 64'(0));
    check("reset_status", 64'({busy, done, fail, fail_addr, fail_bits}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_march(1'b0, -1, 16'h0, 0, 0);           // fault-free, data0 = 0x0000
    run_march(1'b0, 'h0A5, 16'h0008, 0, 0);     // stuck-at-1, bit 3 @ 0x0A5
    run_march(1'b1, -1, 16'h0, 0, 0);           // fault-free, data0 = 0x5555
    run_march(1'b0, -1, 16'h0, 0, 1000);        // reset mid-run
    run_march(1'b0, -1, 16'h0, 0, 0);           // clean run after the abort
    run_march(1'b0, 'h1F0, 16'h8000, 2000, 0);  // START while BUSY is ignored
    run_march(1'($urandom_range(0, 1)), -1, 16'h0, 0, 0);  // rerun clears FAIL

    for (int r = 0; r < 2; r++) begin
      int          fa;
      logic [15:0] fm;
      fa = $urandom_range(0, N - 1);
      fm = 16'(1 << $urandom_range(0, 15)) | 16'($urandom_range(0, 1) << $urandom_range(0, 15));
      run_march(1'($urandom_range(0, 1)), fa, fm, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
